// File: rtl/phase_seq_ctrl.sv
// Traffic-style phase sequencer: IDLE -> GREEN -> YELLOW -> RED -> GREEN/IDLE, each phase T+1 CE ticks.
// Latency: all outputs registered, update on the edge that changes state/counter.
// Backpressure: none; HOLD freezes state and counter, CE gates counting.
module phase_seq_ctrl #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         CE,
    input  logic         START,
    input  logic         STOP,
    input  logic         HOLD,
    input  logic [W-1:0] T_GRN,
    input  logic [W-1:0] T_YEL,
    input  logic [W-1:0] T_RED,
    output logic         GRN,
    output logic         YEL,
    output logic         RED,
    output logic [1:0]   PHASE,
    output logic [W-1:0] REMAIN,
    output logic         TC
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10,
        S_RED    = 2'b11
    } state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic         tc_nxt;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= S_IDLE;
            cnt   <= '0;
            GRN   <= 1'b0;
            YEL   <= 1'b0;
            RED   <= 1'b0;
            TC    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // lamps follow the next state so they change on the same edge as PHASE
            GRN   <= (state_nxt == S_GREEN);
            YEL   <= (state_nxt == S_YELLOW);
            RED   <= (state_nxt == S_RED);
            TC    <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tc_nxt    = 1'b0;
        if (!HOLD) begin
            if (state == S_IDLE) begin
                if (START) begin
                    state_nxt = S_GREEN;
                    cnt_nxt   = T_GRN;
                end
            end else if (CE) begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - W'(1);
                end else begin
                    // terminal tick: advance and load the next phase's duration
                    tc_nxt = 1'b1;
                    unique case (state)
                        S_GREEN: begin
                            state_nxt = S_YELLOW;
                            cnt_nxt   = T_YEL;
                        end
                        S_YELLOW: begin
                            state_nxt = S_RED;
                            cnt_nxt   = T_RED;
                        end
                        S_RED: begin
                            if (STOP) begin
                                state_nxt = S_IDLE;
                                cnt_nxt   = '0;
                            end else begin
                                state_nxt = S_GREEN;
                                cnt_nxt   = T_GRN;
                            end
                        end
                        default: begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end
                    endcase
                end
            end
        end
    end

    assign PHASE  = state;
    assign REMAIN = cnt;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Bench for phase_seq_ctrl: directed scenarios plus random stimulus against a phase/elapsed-tick model.
module tb_phase_seq_ctrl;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         CLR, CE, START, STOP, HOLD;
    logic [W-1:0] T_GRN, T_YEL, T_RED;
    logic         GRN, YEL, RED, TC;
    logic [1:0]   PHASE;
    logic [W-1:0] REMAIN;

    int total = 0;
    int bad   = 0;

    // model: current phase, duration loaded for it, CE ticks already spent in it
    int mdl_phase = 0;
    int mdl_dur   = 0;
    int mdl_el    = 0;
    bit mdl_tc    = 0;

    phase_seq_ctrl #(.W(W)) dut (
        .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .STOP(STOP), .HOLD(HOLD),
        .T_GRN(T_GRN), .T_YEL(T_YEL), .T_RED(T_RED),
        .GRN(GRN), .YEL(YEL), .RED(RED), .PHASE(PHASE), .REMAIN(REMAIN), .TC(TC)
    );

    always #5 CLK = ~CLK;

    wire [W+5:0] obs = {PHASE, REMAIN, GRN, YEL, RED, TC};

    function automatic logic [W+5:0] exp_vec();
        logic [1:0]   p;
        logic [W-1:0] r;
        p = 2'(mdl_phase);
        r = W'(mdl_dur - mdl_el);
        return {p, r, mdl_phase == 1, mdl_phase == 2, mdl_phase == 3, mdl_tc};
    endfunction

    task automatic mdl_step();
        mdl_tc = 0;
        if (CLR) begin
            mdl_phase = 0; mdl_dur = 0; mdl_el = 0;
        end else if (HOLD) begin
            mdl_tc = 0;
        end else if (mdl_phase == 0) begin
            if (START) begin
                mdl_phase = 1; mdl_dur = int'(T_GRN); mdl_el = 0;
            end
        end else if (CE) begin
            if (mdl_el < mdl_dur) begin
                mdl_el++;
            end else begin
                mdl_tc = 1;
                mdl_el = 0;
                if (mdl_phase == 1) begin
                    mdl_phase = 2; mdl_dur = int'(T_YEL);
                end else if (mdl_phase == 2) begin
                    mdl_phase = 3; mdl_dur = int'(T_RED);
                end else if (STOP) begin
                    mdl_phase = 0; mdl_dur = 0;
                end else begin
                    mdl_phase = 1; mdl_dur = int'(T_GRN);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        mdl_step();
        #1;
    endtask

    task automatic idle_inputs();
        CLR = 0; CE = 0; START = 0; STOP = 0; HOLD = 0;
    endtask

    task automatic do_clear();
        idle_inputs();
        CLR = 1;
        tick();
        CLR = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        CLR = 1; START = 1; CE = 1; T_GRN = 4'd3; T_YEL = 4'd1; T_RED = 4'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got=%h want=0", i, obs);
            end
        end
        // first edge after CLR drops must accept START
        CLR = 0;
        tick();
        total++;
        if (obs !== exp_vec() || PHASE !== 2'b01 || REMAIN !== 4'd3) begin
            bad++;
            $display("FAIL reset_release_start got=%h want=%h", obs, exp_vec());
        end
        START = 0;
    endtask

    task automatic test_basic_cycle();
        int exp_ph[7] = '{1, 1, 1, 2, 3, 3, 1};
        int exp_tc[7] = '{0, 0, 0, 1, 1, 0, 1};
        do_clear();
        T_GRN = 4'd2; T_YEL = 4'd0; T_RED = 4'd1; CE = 1; STOP = 0;
        START = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            START = 0;
            total++;
            if (obs !== exp_vec() || int'(PHASE) != exp_ph[i] || int'(TC) != exp_tc[i]) begin
                bad++;
                $display("FAIL basic_cycle i=%0d got=%h model=%h want_phase=%0d want_tc=%0d",
                         i, obs, exp_vec(), exp_ph[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_ce_prescale();
        int green_clks;
        do_clear();
        T_GRN = 4'd1; T_YEL = 4'd0; T_RED = 4'd0;
        START = 1;
        tick();
        START = 0;
        green_clks = 1;
        for (int i = 0; i < 12; i++) begin
            CE = (i % 4 == 3);
            tick();
            if (PHASE == 2'b01) green_clks++;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL ce_prescale i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        CE = 0;
        total++;
        if (green_clks != 8) begin
            bad++;
            $display("FAIL ce_prescale_len got=%0d want=8", green_clks);
        end
    endtask

    task automatic test_hold();
        do_clear();
        T_GRN = 4'd5; T_YEL = 4'd0; T_RED = 4'd0;
        START = 1;
        tick();
        START = 0; CE = 1;
        tick();
        tick();
        HOLD = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (REMAIN !== 4'd3 || PHASE !== 2'b01 || TC !== 1'b0 || obs !== exp_vec()) begin
                bad++;
                $display("FAIL hold i=%0d got=%h want_remain=3 want_phase=1", i, obs);
            end
        end
        HOLD = 0;
        tick();
        total++;
        if (REMAIN !== 4'd2 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL hold_resume got=%h want=%h", obs, exp_vec());
        end
        CE = 0;
    endtask

    task automatic test_stop();
        do_clear();
        T_GRN = 4'd0; T_YEL = 4'd1; T_RED = 4'd0; CE = 1;
        START = 1;
        tick();
        START = 0;
        tick();
        STOP = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL stop_run i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        tick();
        total++;
        if (PHASE !== 2'b00 || {GRN, YEL, RED} !== 3'b000 || TC !== 1'b1 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL stop_to_idle got=%h want=%h", obs, exp_vec());
        end
        tick();
        total++;
        if (PHASE !== 2'b00 || TC !== 1'b0) begin
            bad++;
            $display("FAIL stop_idle_stays got=%h want_phase=0 want_tc=0", obs);
        end
        STOP = 0; START = 1;
        tick();
        START = 0;
        total++;
        if (PHASE !== 2'b01 || GRN !== 1'b1 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL stop_restart got=%h want=%h", obs, exp_vec());
        end
        CE = 0;
    endtask

    task automatic test_clr_mid();
        do_clear();
        T_GRN = 4'd0; T_YEL = 4'd0; T_RED = 4'd5; CE = 1;
        START = 1;
        tick();
        START = 0;
        tick();
        tick();
        total++;
        if (PHASE !== 2'b11 || REMAIN !== 4'd5) begin
            bad++;
            $display("FAIL clr_setup got=%h want_phase=3 want_remain=5", obs);
        end
        CLR = 1; START = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL clr_mid i=%0d got=%h want=0", i, obs);
            end
        end
        CLR = 0; START = 0; CE = 0;
    endtask

    task automatic test_max_duration();
        int n;
        do_clear();
        T_GRN = 4'd15; T_YEL = 4'd0; T_RED = 4'd0; CE = 1;
        START = 1;
        tick();
        START = 0;
        n = 0;
        while (PHASE == 2'b01 && n < 40) begin
            if (n == 4) T_GRN = 4'd2;
            tick();
            n++;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL max_dur_step n=%0d got=%h want=%h", n, obs, exp_vec());
            end
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL max_dur_len got=%0d want=16", n);
        end
        n = 0;
        while (PHASE != 2'b01 && n < 40) begin
            tick();
            n++;
        end
        n = 0;
        while (PHASE == 2'b01 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL reload_len got=%0d want=3", n);
        end
        CE = 0;
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 800; i++) begin
            CLR   = ($urandom_range(0, 49) == 0);
            CE    = ($urandom_range(0, 1) == 1);
            START = ($urandom_range(0, 3) == 0);
            HOLD  = ($urandom_range(0, 7) == 0);
            STOP  = ($urandom_range(0, 2) == 0);
            T_GRN = W'($urandom_range(0, 5));
            T_YEL = W'($urandom_range(0, 3));
            T_RED = W'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) T_GRN = 4'd15;
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        T_GRN = '0; T_YEL = '0; T_RED = '0;
        test_reset();
        test_basic_cycle();
        test_ce_prescale();
        test_hold();
        test_stop();
        test_clr_mid();
        test_max_duration();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_seq_ctrl.md
PHASE_SEQ_CTRL -- requirements
Module: phase_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, meaning the width of the phase-duration counter and all duration inputs.
REQ-002 SHALL have port CLK, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR, input, 1, meaning the synchronous active-high reset, sampled on the CLK rising edge.
REQ-004 SHALL have port CE, input, 1, meaning the count-enable tick (one CLK-wide pulse per time unit from an external prescaler).
REQ-005 SHALL have port START, input, 1, meaning the request to leave IDLE; it is ignored in any other state.
REQ-006 SHALL have port STOP, input, 1, level: return to IDLE at the end of the RED phase instead of wrapping to GREEN.
REQ-007 SHALL have port HOLD, input, 1, meaning freeze the state and the counter while high.
REQ-008 SHALL have ports T_GRN, T_YEL, T_RED, input, W each, meaning phase durations in CE ticks minus one.
REQ-009 SHALL have ports GRN, YEL, RED, output, 1 each, meaning the registered one-hot lamp outputs.
REQ-010 SHALL have port PHASE, output, 2, meaning the registered state code: IDLE=00, GREEN=01, YELLOW=10, RED=11.
REQ-011 SHALL have port REMAIN, output, W, meaning the registered current down-counter value.
REQ-012 SHALL have port TC, output, 1, meaning a registered one-CLK pulse on every phase change out of GREEN, YELLOW or RED.

Function
REQ-013 SHALL implement the four-state FSM IDLE, GREEN, YELLOW and RED, with the counter a W-bit down-counter owned by the block.
REQ-014 SHALL move from IDLE to GREEN on the first edge where START=1 and HOLD=0 (CE not required), loading REMAIN with T_GRN on that edge.
REQ-015 SHALL, in a counting state with CE=1, HOLD=0 and REMAIN>0, decrement REMAIN by 1 on that edge.
REQ-016 SHALL, in a counting state with CE=1, HOLD=0 and REMAIN=0, advance GREEN->YELLOW (load T_YEL) or YELLOW->RED (load T_RED); from RED it SHALL go to IDLE with REMAIN=0 if STOP=1 on that edge, otherwise to GREEN (load T_GRN).
REQ-017 SHALL sample each duration input only on the edge that loads it; changes during a phase SHALL not affect that phase.
REQ-018 SHALL make each phase last exactly T+1 qualifying CE ticks; T=0 gives a one-tick phase, and T=2^W-1 gives 2^W ticks with no wrap-around.
REQ-019 SHALL assert TC for exactly the one CLK cycle following each phase-advance edge, and SHALL keep TC low for the IDLE->GREEN start.
REQ-020 SHALL drive GRN, YEL and RED one-hot in the matching state and all zero in IDLE, updating them in the same cycle as PHASE.
REQ-021 SHALL apply precedence CLR > HOLD > CE; HOLD=1 SHALL also block START and keep TC low.
REQ-022 SHALL leave REMAIN and the state unchanged when CE=0.
REQ-023 SHALL treat STOP as a level sampled only at the RED terminal edge; STOP in other states SHALL have no effect.

Reset
REQ-024 SHALL, on any edge with CLR=1, force PHASE=00, REMAIN=0, GRN=YEL=RED=0 and TC=0, regardless of all other inputs, including mid-phase.
REQ-025 SHALL, on the first edge after CLR deasserts, behave as IDLE, so START on that edge is accepted.

Verification
REQ-026 SHALL pass this scenario: W=4, T_GRN=2, T_YEL=0, T_RED=1, CE=1 continuously, START pulse, STOP=0 -> GREEN for 3 CLKs, YELLOW 1, RED 2, then GREEN again; TC pulses after each advance.
REQ-027 SHALL pass this scenario: CE pulsing every 4th CLK, T_GRN=1 -> GREEN persists for 2 CE ticks (about 8 CLKs); REMAIN steps 1->0 only on CE edges.
REQ-028 SHALL pass this scenario: HOLD=1 for 5 CLKs mid-GREEN with REMAIN=3 and CE=1 -> REMAIN stays 3 and PHASE stays 01; the count resumes after release.
REQ-029 SHALL pass this scenario: STOP=1 raised during YELLOW, T_RED=0 -> RED lasts 1 tick, then PHASE=00, all lamps 0, TC=1 for one CLK; a later START restarts GREEN.
REQ-030 SHALL pass this scenario: CLR=1 asserted in RED with REMAIN=5 -> next edge PHASE=00, REMAIN=0, lamps 0; CLR held with START=1 -> remains IDLE.
REQ-031 SHALL pass this scenario: T_GRN=15 (max) -> GREEN lasts exactly 16 CE ticks; T_GRN changed to 2 mid-phase -> current phase unaffected, next GREEN lasts 3.
